// File: rtl/div32_pkg.sv
// div32_pkg: shared definitions for the iterative RV32M divider.
//   - op encodings (funct3[1:0]) for DIV/DIVU/REM/REMU
//   - FSM state type
//   - iteration count and the most-negative 32-bit integer
package div32_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_t;

  localparam int unsigned DIV_ITER = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // funct3[0]=0 selects the signed flavours (DIV, REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // funct3[1]=1 selects the remainder flavours (REM, REMU).
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div32_fa32.sv
// fa32: 32-bit adder in subtract mode, shared with the divider datapath.
//   a    in  32  minuend
//   b    in  32  subtrahend (inverted internally)
//   cin  in   1  carry in; 1 gives a - b
//   sum  out 32  a + ~b + cin
//   cout out  1  carry out; with cin=1, 1 means no borrow (a >= b)
module fa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {32'b0, cin};

endmodule

// File: rtl/div32.sv
// div32: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request a division; only honoured when busy=0
//   op     in   2  00=DIV 01=DIVU 10=REM 11=REMU
//   A      in  32  dividend, sampled with start
//   B      in  32  divisor, sampled with start
//   busy   out  1  division in flight (CALC/FIX); pipeline stalls
//   done   out  1  one-cycle pulse, result valid
//   result out 32  quotient or remainder, held until the next accepted start
// Normal ops take 32 CALC cycles plus one FIX cycle; divide-by-zero and
// signed overflow bypass the datapath and finish the cycle after start.
module div32
  import div32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_t  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Operand magnitudes for the incoming request.
  logic        in_signed;
  logic [31:0] abs_a, abs_b;

  assign in_signed = op_is_signed(op);
  assign abs_a     = (in_signed && A[31]) ? ~A + 32'd1 : A;
  assign abs_b     = (in_signed && B[31]) ? ~B + 32'd1 : B;

  // One restoring step: trial-subtract |B| from the shifted partial remainder.
  logic [31:0] shifted_r;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        qb;

  assign shifted_r = {r_q[30:0], q_q[31]};

  fa32 u_fa32 (
    .a    (shifted_r),
    .b    (b_q),
    .cin  (1'b1),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // r_q[31] set means the 33-bit partial remainder exceeds any 32-bit divisor.
  assign qb = r_q[31] | add_cout;

  // Sign-corrected final values for the FIX step.
  logic [31:0] q_fix, r_fix;

  assign q_fix = qneg_q ? ~q_q + 32'd1 : q_q;
  assign r_fix = rneg_q ? ~r_q + 32'd1 : r_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      r_q      <= r_d;
      q_q      <= q_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    r_d      = r_q;
    q_d      = q_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          op_d   = op;
          qneg_d = in_signed & (A[31] ^ B[31]);
          rneg_d = in_signed & A[31];
          if (B == 32'd0) begin
            state_d  = StDone;
            result_d = op_is_rem(op) ? A : 32'hFFFF_FFFF;
          end else if (in_signed && (A == INT_MIN) && (B == 32'hFFFF_FFFF)) begin
            state_d  = StDone;
            result_d = op_is_rem(op) ? 32'd0 : INT_MIN;
          end else begin
            state_d = StCalc;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = abs_a;
            b_d     = abs_b;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        r_d   = qb ? add_sum : shifted_r;
        q_d   = {q_q[30:0], qb};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = op_is_rem(op_q) ? r_fix : q_fix;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StCalc, StFix: busy = 1'b1;
      StDone:        done = 1'b1;
      default:       ;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_div32.sv
module tb_div32;
  import div32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div32 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using wide signed arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      DIVU_OP: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU_OP: return (b == 0) ? a : a % b;
      DIV_OP: begin
        if (b == 0) return 32'hFFFF_FFFF;
        t = sa / sb;
        return t[31:0];
      end
      default: begin
        if (b == 0) return a;
        t = sa % sb;
        return t[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op from idle; returns result, done cycle (start cycle = 0) and
  // whether busy was ever seen high before done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit saw_busy);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    saw_busy = 1'b0;
    while (!done && lat < 100) begin
      saw_busy |= busy;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          sb;
    int          cyc;
    bit          saw_done;

    vecs[0] = '{DIVU_OP, 32'd100,        32'd7,          32'd14,         34};
    vecs[1] = '{REMU_OP, 32'd100,        32'd7,          32'd2,          34};
    vecs[2] = '{DIV_OP,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3] = '{REM_OP,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4] = '{DIVU_OP, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[5] = '{REMU_OP, 32'h1234_5678,  32'd0,          32'h1234_5678,  1};
    vecs[6] = '{DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7] = '{REM_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8] = '{DIVU_OP, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[9] = '{REMU_OP, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, sb);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_seen", i), {31'd0, sb}, (vecs[i].lat == 1) ? 32'd0 : 32'd1);
    end

    // start during cycle 10 of a division is ignored.
    @(negedge clk);
    op = DIVU_OP; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 10) begin
        start = 1'b1; op = REMU_OP; a_in = 32'd5; b_in = 32'd3;
      end
      if (done) break;
    end
    start = 1'b0;
    check("ignored_start_latency", cyc, 34);
    check("ignored_start_result", result, 32'd14);

    // Back-to-back: new start in the DONE cycle.
    do_op(DIVU_OP, 32'd100, 32'd7, res, lat, sb);
    check("b2b_first_result", res, 32'd14);
    op = REMU_OP; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
      if (done) break;
    end
    check("b2b_second_latency", cyc, 34);
    check("b2b_second_result", result, 32'd2);

    // Reset in cycle 15 aborts with no done pulse.
    @(negedge clk);
    op = DIVU_OP; a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      saw_done |= done;
      @(negedge clk);
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 300));
        4:       rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, res, lat, sb);
      check($sformatf("rand%0d_op%0d_result", i, ro), res, ref_result(ro, ra, rb));
      check($sformatf("rand%0d_latency", i), lat, ref_latency(ro, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
